// File: rtl/keypoint_merge_reader_pkg.sv
// kp_pkg: shared widths, layer tags and merge FSM states for keypoint_merge_reader.
package kp_pkg;
   localparam int KP_ADDR_W  = 11;
   localparam int KP_COORD_W = 19;
   typedef enum logic [1:0] {LAYER_NONE = 2'b00, LAYER1 = 2'b01, LAYER2 = 2'b10, BOTH = 2'b11} kp_layer_t;
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, MERGE, REFILL, DONE} kp_state_t;
endpackage

// File: rtl/keypoint_merge_reader_if.sv
// keypoint_merge_reader_if: layer-tagged merged keypoint stream (valid/ready).
interface keypoint_merge_reader_if #(parameter int COORD_W = kp_pkg::KP_COORD_W);
   logic               valid;
   logic               ready;
   logic [COORD_W-1:0] data;
   kp_pkg::kp_layer_t  layer;
   modport master (output valid, data, layer, input ready);
   modport slave  (input valid, data, layer, output ready);
endinterface

// File: rtl/keypoint_merge_reader_stream_head.sv
// kp_stream_head: per-layer read index, SRAM address and head register of one merge input.
// The address leads the head by one entry so each REFILL finds its word already on dout.
module kp_stream_head
   import kp_pkg::*;
#(
   parameter int ADDR_W  = KP_ADDR_W,
   parameter int COORD_W = KP_COORD_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               init_i,
   input  logic               load_i,
   input  logic               adv_i,
   input  logic               cap_i,
   input  logic [ADDR_W:0]    count_i,
   input  logic [COORD_W-1:0] dout_i,
   output logic [ADDR_W-1:0]  addr_o,
   output logic [COORD_W-1:0] head_o,
   output logic               vld_o,
   output logic               more_o
);
   logic [ADDR_W:0]    cnt_q, cnt_d, idx_q, idx_d, nxt;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [COORD_W-1:0] head_q, head_d;
   logic               vld_q, vld_d;

   assign nxt    = idx_q + 1'b1;
   assign more_o = nxt < cnt_q;

   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      addr_d = addr_q;
      head_d = head_q;
      vld_d  = vld_q;
      if (init_i) begin
         cnt_d  = count_i;
         idx_d  = '0;
         addr_d = '0;
         vld_d  = 1'b0;
      end else if (load_i || cap_i) begin
         head_d = dout_i;
         vld_d  = load_i ? cnt_q != '0 : vld_q;
         addr_d = more_o ? nxt[ADDR_W-1:0] : addr_q;
      end else if (adv_i) begin
         idx_d = nxt;
         vld_d = more_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         addr_q <= '0;
         head_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         addr_q <= addr_d;
         head_q <= head_d;
         vld_q  <= vld_d;
      end
   end

   assign addr_o = addr_q;
   assign head_o = head_q;
   assign vld_o  = vld_q;
endmodule

// File: rtl/keypoint_merge_reader.sv
// keypoint_merge_reader: raster-order two-way merge of the per-layer keypoint SRAMs into
// one layer-tagged stream. Define KPM_DEDUP_EN to fold equal words into one BOTH word.
module keypoint_merge_reader
   import kp_pkg::*;
#(
   parameter int ADDR_W  = KP_ADDR_W,
   parameter int COORD_W = KP_COORD_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic [ADDR_W:0]         kp1_count_i,
   input  logic [ADDR_W:0]         kp2_count_i,
   output logic [ADDR_W-1:0]       kp1_addr_o,
   input  logic [COORD_W-1:0]      kp1_dout_i,
   output logic [ADDR_W-1:0]       kp2_addr_o,
   input  logic [COORD_W-1:0]      kp2_dout_i,
   output logic                    busy_o,
   output logic                    done_o,
   keypoint_merge_reader_if.master kp_if
);
   kp_state_t          state_q, state_d;
   kp_layer_t          layer_q, layer_d;
   logic [COORD_W-1:0] data_q, data_d, head1, head2;
   logic [1:0]         cap_q, cap_d, adv, pick, vld, more;
   logic               valid_q, valid_d, free, init, load, w1, tie;

   assign init = state_q == IDLE && start_i;
   assign load = state_q == LOAD;
   assign free = !valid_q || kp_if.ready;

   kp_stream_head #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) u_s1 (
      .clk, .rst_n, .init_i(init), .load_i(load), .adv_i(adv[0]),
      .cap_i(state_q == REFILL && cap_q[0]), .count_i(kp1_count_i), .dout_i(kp1_dout_i),
      .addr_o(kp1_addr_o), .head_o(head1), .vld_o(vld[0]), .more_o(more[0])
   );

   kp_stream_head #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) u_s2 (
      .clk, .rst_n, .init_i(init), .load_i(load), .adv_i(adv[1]),
      .cap_i(state_q == REFILL && cap_q[1]), .count_i(kp2_count_i), .dout_i(kp2_dout_i),
      .addr_o(kp2_addr_o), .head_o(head2), .vld_o(vld[1]), .more_o(more[1])
   );

   // Smaller word wins; layer 1 wins ties unless they are folded together
   always_comb begin
      w1  = vld[0] && (!vld[1] || head1 <= head2);
      tie = &vld && head1 == head2;
`ifdef KPM_DEDUP_EN
      pick = tie ? 2'b11 : {!w1, w1};
`else
      pick = tie ? 2'b01 : {!w1, w1};
`endif
   end

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      adv     = '0;
      valid_d = valid_q && !kp_if.ready;
      data_d  = data_q;
      layer_d = layer_q;
      case (state_q)
         IDLE:   state_d = start_i ? FETCH : IDLE;
         FETCH:  state_d = LOAD;
         LOAD:   state_d = MERGE;
         MERGE: begin
            if (vld == 2'b00) begin
               state_d = free ? DONE : MERGE;
            end else if (free) begin
               adv     = pick;
               valid_d = 1'b1;
               data_d  = pick[0] ? head1 : head2;
               layer_d = kp_layer_t'(pick);
               cap_d   = pick & more;
               state_d = |(pick & more) ? REFILL : MERGE;
            end
         end
         REFILL: state_d = MERGE;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cap_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         layer_q <= LAYER_NONE;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         layer_q <= layer_d;
      end
   end

   assign kp_if.valid = valid_q;
   assign kp_if.data  = data_q;
   assign kp_if.layer = layer_q;
   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == DONE;
endmodule
